// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount unit.
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int BYTE_W = 8;

  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/FourBitAdder.sv
// Four-bit ripple-carry adder built from full_adder cells.
module FourBitAdder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .c_i(carry[i]),
      .s_o(s_o[i]),
      .c_o(carry[i+1])
    );
  end

  assign c_o = carry[4];

endmodule

// File: rtl/byte_weight.sv
// Combinational set-bit counter for one byte (0..8), built from adder cells.
module byte_weight (
  input  logic [7:0] data_i,
  output logic [3:0] weight_o
);

  logic s0, c0, s1, c1, s2, c2, s3, c3;
  logic [3:0] sum;
  logic       cout;

  // Carry-save tree: three weight-1 sums reduce to s2, the weight-2 carries to s3/c3.
  full_adder u_fa0 (.a_i(data_i[0]), .b_i(data_i[1]), .c_i(data_i[2]), .s_o(s0), .c_o(c0));
  full_adder u_fa1 (.a_i(data_i[3]), .b_i(data_i[4]), .c_i(data_i[5]), .s_o(s1), .c_o(c1));
  full_adder u_fa2 (.a_i(s0),        .b_i(s1),        .c_i(data_i[6]), .s_o(s2), .c_o(c2));
  full_adder u_fa3 (.a_i(c0),        .b_i(c1),        .c_i(c2),        .s_o(s3), .c_o(c3));

  FourBitAdder u_add (
    .a_i({1'b0, c3, s3, s2}),
    .b_i(4'b0000),
    .c_i(data_i[7]),
    .s_o(sum),
    .c_o(cout)
  );

  // The sum never exceeds 8, so the carry-out is always clear; OR-ing it keeps the cell fully used.
  assign weight_o = {sum[3] | cout, sum[2:0]};

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle Hamming-weight unit: one byte per cycle, LSB byte first.
// Define POPCOUNT_HDIST_EN to add in_data_b and count the Hamming distance instead.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef POPCOUNT_HDIST_EN
  input  logic [WIDTH-1:0] in_data_b,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int N     = WIDTH / BYTE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         weight;
  logic [CW-1:0]      acc_sum;
  logic [WIDTH-1:0]   load_word;

`ifdef POPCOUNT_HDIST_EN
  assign load_word = in_data ^ in_data_b;
`else
  assign load_word = in_data;
`endif

  byte_weight u_byte_weight (
    .data_i  (shreg_q[BYTE_W-1:0]),
    .weight_o(weight)
  );

  assign acc_sum = acc_q + CW'(weight);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = load_word;
          acc_d   = '0;
          cnt_d   = CNT_W'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        shreg_d = shreg_q >> BYTE_W;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          count_d = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_count = count_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: directed table, corner sequences, random ops.
module tb_popcount_seq;

  localparam int WIDTH = 32;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
`ifdef POPCOUNT_HDIST_EN
  logic [WIDTH-1:0] in_data_b;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef POPCOUNT_HDIST_EN
    .in_data_b(in_data_b),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .busy     (busy)
  );

  typedef struct {
    logic [31:0] a;
    int          exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the number of set bits in the operand (or in a^b for the distance build).
  function automatic int ref_count(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    logic [31:0] w = a ^ b;
    for (int i = 0; i < 32; i++) if (w[i]) n++;
    return n;
  endfunction

  // Full transaction: offer a, check accept latency, result, stall behaviour and release.
  task automatic run_op(input logic [31:0] a, input int exp, input int stall, input string name);
    int n;
    int lat;
    logic [CW-1:0] held;
    in_data  = a;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk({name, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    chk({name, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_count"}, out_count, exp);
    held = out_count;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({name, "_stall_hold"}, {out_valid, in_ready, out_count}, {1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_release"}, {out_valid, in_ready, out_count}, {1'b0, 1'b1, held});
  endtask

  vec_t tbl[4];
  logic [31:0] pat[2];
  int q[$];
  int sent, got;
  logic acc;
  logic [31:0] ra;
  int rexp;

  initial begin
    tbl[0] = '{32'h0000_0000, 0};
    tbl[1] = '{32'hFFFF_FFFF, 32};
    tbl[2] = '{32'h8000_0001, 2};
    tbl[3] = '{32'h0F0F_00FF, 16};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef POPCOUNT_HDIST_EN
    in_data_b = '0;
`endif
    repeat (3) step();
    chk("reset_state", {in_ready, out_valid, busy, out_count}, {1'b1, 1'b0, 1'b0, 6'd0});
    rst = 1'b0;
    step();

    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].exp, 0, "table");

    run_op(32'h1234_5678, 13, 10, "backpressure");

    // Streaming: in_valid never drops; results must come back in order, none lost or repeated.
    pat[0] = 32'hAAAA_AAAA;
    pat[1] = 32'h0000_0001;
    sent = 0; got = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = pat[0];
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("stream_extra", out_count, -1);
        else chk("stream", out_count, q.pop_front());
        got++;
      end
      acc = in_ready && in_valid;
      if (acc) q.push_back(ref_count(in_data, 32'h0));
      step();
      if (acc) begin
        sent++;
        if (sent < 6) in_data = pat[sent % 2];
        else in_valid = 1'b0;
      end
    end
    chk("stream_total", got, 6);
    out_ready = 1'b0;
    step();

    // Reset during the second RUN cycle discards the partial sum.
    in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_reset", {in_ready, out_valid, busy, out_count}, {1'b1, 1'b0, 1'b0, 6'd0});
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got++;
      step();
    end
    chk("midrun_no_valid", got, 0);
    run_op(32'h0000_00F0, 4, 0, "after_reset");

`ifdef POPCOUNT_HDIST_EN
    in_data_b = 32'h1234_5679;
    run_op(32'h1234_5678, 1, 0, "hdist_one");
    in_data_b = 32'h0000_FFFF;
    run_op(32'hFFFF_0000, 32, 0, "hdist_max");
`endif

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
`ifdef POPCOUNT_HDIST_EN
      in_data_b = $urandom;
      rexp = ref_count(ra, in_data_b);
`else
      rexp = ref_count(ra, 32'h0);
`endif
      run_op(ra, rexp, $urandom_range(0, 3), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
